// File: rtl/reload_counter_pkg.sv
// reload_counter_pkg: mode codes and FSM state encoding shared by the
// reload_counter block.
package reload_counter_pkg;

  localparam logic [1:0] MODE_UP      = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_RELOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/reload_counter_cnt_prescaler.sv
// cnt_prescaler: counts enabled clocks and emits a tick when the count
// equals div, then wraps to 0. clr (a counter load) restarts the period.
module cnt_prescaler #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] r_psc;
  logic         w_term;

  assign w_term = (r_psc == div);
  assign tick   = en & w_term;

  // Prescale counter; frozen while en is low, cleared by reset or load.
  always_ff @(posedge clk) begin
    if (reset || clr)  r_psc <= '0;
    else if (en) begin
      if (w_term)      r_psc <= '0;
      else             r_psc <= r_psc + 1'b1;
    end
  end

endmodule

// File: rtl/reload_counter.sv
// reload_counter: loadable up/down counter with one-shot and auto-reload
// modes, terminal-count pulse and busy flag.
// Optional prescaler enabled by defining RELOAD_CNT_PRESCALE_EN; without it
// psc_div is ignored and every enabled clock is a tick.
module reload_counter
  import reload_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  wr,
  input  logic [1:0]            mode,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] psc_div,
  output logic [WIDTH-1:0]      data_cnt,
  output logic                  tc,
  output logic                  busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             w_tick;

`ifdef RELOAD_CNT_PRESCALE_EN
  cnt_prescaler #(.W(PRESCALE_W)) u_psc (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (wr),
    .div   (psc_div),
    .tick  (w_tick)
  );
`else
  logic w_unused_psc;
  assign w_unused_psc = ^psc_div;
  assign w_tick       = en;
`endif

  // FSM, count, reload and tc; a load beats a same-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (wr) begin
        r_reload <= wdata;
        r_cnt    <= wdata;
        r_state  <= ST_RUN;
      end else if (w_tick && r_state == ST_RUN) begin
        case (mode)
          MODE_UP: begin
            r_cnt <= r_cnt + 1'b1;
            r_tc  <= (r_cnt == '1);
          end
          MODE_DOWN: begin
            r_cnt <= r_cnt - 1'b1;
            r_tc  <= (r_cnt == '0);
          end
          MODE_ONESHOT: begin
            // 1->0 and an already-zero count both finish the shot at 0.
            if (r_cnt <= WIDTH'(1)) begin
              r_cnt   <= '0;
              r_tc    <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: begin
            if (r_cnt == '0) begin
              r_cnt <= r_reload;
              r_tc  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign data_cnt = r_cnt;
  assign tc       = r_tc;
  assign busy     = (r_state == ST_RUN);

endmodule

// File: tb/tb_reload_counter.sv
// tb_reload_counter: directed vectors for reload_counter (WIDTH=8).
// Inputs are driven and outputs sampled on the falling edge.
module tb_reload_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wdata;
  logic       wr;
  logic [1:0] mode;
  logic       en;
  logic [3:0] psc_div;
  logic [7:0] data_cnt;
  logic       tc;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  reload_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .wdata    (wdata),
    .wr       (wr),
    .mode     (mode),
    .en       (en),
    .psc_div  (psc_div),
    .data_cnt (data_cnt),
    .tc       (tc),
    .busy     (busy)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // check count, tc and busy together
  task automatic chk3(input string tag, input logic [7:0] c, input logic t, input logic b);
    chk({tag, ".cnt"},  32'(data_cnt), 32'(c));
    chk({tag, ".tc"},   32'(tc),       32'(t));
    chk({tag, ".busy"}, 32'(busy),     32'(b));
  endtask

  task automatic load(input logic [7:0] v, input logic [1:0] m);
    wdata = v; mode = m; wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wdata = '0; wr = 1'b0; mode = 2'b00; en = 1'b0; psc_div = 4'd0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    // 1. reset state, idle does not count
    chk3("rst", 8'h00, 1'b0, 1'b0);
    en = 1'b1;
    cyc(); chk3("idle", 8'h00, 1'b0, 1'b0);

    // 2. up count from 55
    load(8'h55, 2'b00); chk3("up0", 8'h55, 1'b0, 1'b1);
    cyc(); chk3("up1", 8'h56, 1'b0, 1'b1);
    cyc(); chk3("up2", 8'h57, 1'b0, 1'b1);

    // 3. up wrap
    load(8'hFE, 2'b00); chk3("wr0", 8'hFE, 1'b0, 1'b1);
    cyc(); chk3("wr1", 8'hFF, 1'b0, 1'b1);
    cyc(); chk3("wr2", 8'h00, 1'b1, 1'b1);
    cyc(); chk3("wr3", 8'h01, 1'b0, 1'b1);

    // 4. one-shot from 3, then re-arm
    load(8'd3, 2'b10); chk3("os0", 8'd3, 1'b0, 1'b1);
    cyc(); chk3("os1", 8'd2, 1'b0, 1'b1);
    cyc(); chk3("os2", 8'd1, 1'b0, 1'b1);
    cyc(); chk3("os3", 8'd0, 1'b1, 1'b0);
    cyc(); chk3("os4", 8'd0, 1'b0, 1'b0);
    cyc(); chk3("os5", 8'd0, 1'b0, 1'b0);
    load(8'd5, 2'b10); chk3("os6", 8'd5, 1'b0, 1'b1);
    // one-shot loaded with 0 finishes on the first tick
    load(8'd0, 2'b10); chk3("oz0", 8'd0, 1'b0, 1'b1);
    cyc(); chk3("oz1", 8'd0, 1'b1, 1'b0);

    // 5. auto-reload from 2
    load(8'd2, 2'b11); chk3("ar0", 8'd2, 1'b0, 1'b1);
    cyc(); chk3("ar1", 8'd1, 1'b0, 1'b1);
    cyc(); chk3("ar2", 8'd0, 1'b0, 1'b1);
    cyc(); chk3("ar3", 8'd2, 1'b1, 1'b1);
    cyc(); chk3("ar4", 8'd1, 1'b0, 1'b1);
    cyc(); chk3("ar5", 8'd0, 1'b0, 1'b1);
    // load collides with the reloading tick: load wins, no tc
    load(8'h10, 2'b11); chk3("arw", 8'h10, 1'b0, 1'b1);
    // mode change mid-run, no restart
    mode = 2'b00;
    cyc(); chk3("mchg", 8'h11, 1'b0, 1'b1);
    // reload value 0: tc on every tick
    load(8'd0, 2'b11); chk3("rz0", 8'd0, 1'b0, 1'b1);
    cyc(); chk3("rz1", 8'd0, 1'b1, 1'b1);
    cyc(); chk3("rz2", 8'd0, 1'b1, 1'b1);

`ifdef RELOAD_CNT_PRESCALE_EN
    // 6. prescaled down count, psc_div=3
    psc_div = 4'd3;
    load(8'd4, 2'b01); chk3("ps0", 8'd4, 1'b0, 1'b1);
    cyc(); chk3("ps1", 8'd4, 1'b0, 1'b1);
    cyc(); chk3("ps2", 8'd4, 1'b0, 1'b1);
    cyc(); chk3("ps3", 8'd4, 1'b0, 1'b1);
    cyc(); chk3("ps4", 8'd3, 1'b0, 1'b1);
    cyc(); chk3("ps5", 8'd3, 1'b0, 1'b1);
    en = 1'b0;
    cyc(); chk3("fz0", 8'd3, 1'b0, 1'b1);
    cyc(); chk3("fz1", 8'd3, 1'b0, 1'b1);
    en = 1'b1;
    cyc(); chk3("fz2", 8'd3, 1'b0, 1'b1);
    cyc(); chk3("fz3", 8'd3, 1'b0, 1'b1);
    cyc(); chk3("fz4", 8'd2, 1'b0, 1'b1);
`else
    // 6. down count with freeze and wrap
    load(8'd4, 2'b01); chk3("dn0", 8'd4, 1'b0, 1'b1);
    cyc(); chk3("dn1", 8'd3, 1'b0, 1'b1);
    en = 1'b0;
    cyc(); chk3("fz0", 8'd3, 1'b0, 1'b1);
    cyc(); chk3("fz1", 8'd3, 1'b0, 1'b1);
    en = 1'b1;
    cyc(); chk3("dn2", 8'd2, 1'b0, 1'b1);
    cyc(); chk3("dn3", 8'd1, 1'b0, 1'b1);
    cyc(); chk3("dn4", 8'd0, 1'b0, 1'b1);
    cyc(); chk3("dn5", 8'hFF, 1'b1, 1'b1);
    cyc(); chk3("dn6", 8'hFE, 1'b0, 1'b1);
`endif

    // reset mid-run beats a simultaneous load
    reset = 1'b1; wr = 1'b1; wdata = 8'hA5;
    cyc(); chk3("rstrun", 8'h00, 1'b0, 1'b0);
    reset = 1'b0; wr = 1'b0;
    cyc(); chk3("rstidle", 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
